ddr5_bank_cmd_sequencer: RTL
============================

DDR5_BANK_CMD_SEQUENCER -- requirements
Module: ddr5_bank_cmd_sequencer

Interface
REQ-001 Parameters (DRAM clocks; name, default, meaning): T_RCD 39 ACT0-to-CAS0; T_CL 40 RD0-to-read-burst; T_CWD 38 WR0-to-write-burst; T_RAS 76 ACT0-to-PRE minimum; T_RP 39 PRE-to-next-ACT0; T_RTP 18 RD0-to-PRE; T_WR 72 write-recovery after write burst end; T_BURST 8 burst length.
REQ-002 Parameter legality: T_RCD>=2, T_RP>=2, T_BURST>=1, T_RAS>T_RCD+1; all values <=255.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 req_valid  in  1  upstream request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_op  in  2  0=d_read, 1=write, 2=i_read, 3=illegal.
REQ-009 req_row  in  16; req_col  in  10 ({col_high,col_low}); req_bank  in  2; req_bg  in  3.
REQ-010 cmd_valid  out  1  cmd holds a non-NULL command this cycle.
REQ-011 cmd  out  4  0=NULL, 1=ACT0, 2=ACT1, 3=RD0, 4=RD1, 5=WR0, 6=WR1, 7=PRE.
REQ-012 cmd_bg out 3, cmd_bank out 2, cmd_row out 16, cmd_col out 10  address of the in-flight request; zero when cmd_valid=0.
REQ-013 burst_active  out  1  data bus occupied by this request.
REQ-014 err_op  out  1  one-cycle pulse on acceptance of req_op=3.

Function
REQ-015 Handshake: transfer occurs in a cycle where req_valid&&req_ready; req_valid while req_ready=0 is ignored and not latched.
REQ-016 Transfer stores op/row/col/bank/bg internally; stored values stay constant until the request retires.
REQ-017 States: IDLE, ACT0, ACT1, WAIT_CAS, CAS0, CAS1, WAIT_PRE, PRE, WAIT_RP.
REQ-018 req_ready=1 only in IDLE.
REQ-019 Accepting req_op=3: err_op=1 in the following cycle; no command is issued; FSM stays in IDLE.
REQ-020 Legal request accepted in cycle a: ACT0 at a+1, ACT1 at a+2 (cmd_row valid on both).
REQ-021 CAS0 (RD0 for ops 0/2, WR0 for op 1) at ACT0+T_RCD; CAS1 (RD1/WR1) in the next cycle; cmd_col valid on both.
REQ-022 burst_active=1 for exactly T_BURST cycles starting at RD0+T_CL (read) or WR0+T_CWD (write); independent of FSM state.
REQ-023 PRE issued at the later of ACT0+T_RAS and RD0+T_RTP (read) or WR0+T_CWD+T_BURST+T_WR (write).
REQ-024 After PRE in cycle p, FSM re-enters IDLE with req_ready=1 at cycle p+T_RP-1, so the earliest next ACT0 is p+T_RP.
REQ-025 Outside the cycles named in REQ-020..023, cmd=NULL, cmd_valid=0.
REQ-026 Elapsed-time counters are 9-bit, reference ACT0 or CAS0, and saturate at 511 (no wrap).
REQ-027 One request in flight; no command reordering, no refresh handling.

Reset
REQ-028 reset_n=0 sampled at a rising edge: next cycle FSM=IDLE, req_ready=1, cmd_valid=0, cmd=NULL, all cmd_* address outputs=0, burst_active=0, err_op=0, counters=0.
REQ-029 Reset mid-operation (any state, including during burst_active) discards the in-flight request; no PRE is issued for it.
REQ-030 A request presented while reset_n=0 is not accepted.

Verification
REQ-031 Read, defaults: accept op=0, row=16'h1234, col=10'h3F, bank=2, bg=5 at cycle 0 -> ACT0@1, ACT1@2, RD0@40, RD1@41, burst_active 80..87, PRE@77, req_ready@115.
REQ-032 Write, defaults: accept op=1 at cycle 0 -> WR0@40, WR1@41, burst_active 78..85, PRE@158, req_ready@196.
REQ-033 Back-to-back: req_valid held high across two reads -> second ACT0 exactly T_RP (39) cycles after first PRE; no accept while req_ready=0.
REQ-034 Illegal op: accept op=3 -> err_op=1 for one cycle, cmd_valid stays 0, req_ready stays 1.
REQ-035 Reset during WAIT_PRE (cycle 60 of a read) -> next cycle all outputs at reset values, no PRE; new request accepted and sequenced normally.
REQ-036 Parameter override T_RAS=10, T_RCD=3, T_RTP=20: read accepted at 0 -> RD0@4, PRE@24 (T_RTP bound dominates).

Source files
------------

// File: rtl/ddr5_bank_cmd_sequencer.sv
// Sequences one DDR5 bank access per request: ACT0/ACT1, CAS0/CAS1 (RD or WR), then PRE.
// Latency: ACT0 one cycle after accept; CAS0 at ACT0+T_RCD; PRE at the later of the tRAS and tRTP/tWR bounds.
// Backpressure: req_ready is high only in IDLE, so a single request is in flight until tRP has mostly elapsed.
// Ports: clock/reset_n (sync, active-low); req_* upstream request; cmd_* command bus; burst_active data-bus busy; err_op illegal-op pulse.
module ddr5_bank_cmd_sequencer #(
    parameter int unsigned T_RCD   = 39,
    parameter int unsigned T_CL    = 40,
    parameter int unsigned T_CWD   = 38,
    parameter int unsigned T_RAS   = 76,
    parameter int unsigned T_RP    = 39,
    parameter int unsigned T_RTP   = 18,
    parameter int unsigned T_WR    = 72,
    parameter int unsigned T_BURST = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_row,
    input  logic [9:0]  req_col,
    input  logic [1:0]  req_bank,
    input  logic [2:0]  req_bg,
    output logic        cmd_valid,
    output logic [3:0]  cmd,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_bank,
    output logic [15:0] cmd_row,
    output logic [9:0]  cmd_col,
    output logic        burst_active,
    output logic        err_op
);

    typedef enum logic [3:0] {
        S_IDLE, S_ACT0, S_ACT1, S_WAIT_CAS, S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE, S_WAIT_RP
    } state_t;

    localparam logic [3:0] CMD_NULL = 4'd0;
    localparam logic [3:0] CMD_ACT0 = 4'd1;
    localparam logic [3:0] CMD_ACT1 = 4'd2;
    localparam logic [3:0] CMD_RD0  = 4'd3;
    localparam logic [3:0] CMD_RD1  = 4'd4;
    localparam logic [3:0] CMD_WR0  = 4'd5;
    localparam logic [3:0] CMD_WR1  = 4'd6;
    localparam logic [3:0] CMD_PRE  = 4'd7;

    localparam logic [1:0] OP_WRITE   = 2'd1;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    // Timing limits in 10 bits so sums of 8-bit parameters and counter+1 never overflow.
    localparam logic [9:0] RCD_L    = 10'(T_RCD);
    localparam logic [9:0] RAS_L    = 10'(T_RAS);
    localparam logic [9:0] RTP_L    = 10'(T_RTP);
    localparam logic [9:0] WR_PRE_L = 10'(T_CWD + T_BURST + T_WR);
    localparam logic [9:0] CL_L     = 10'(T_CL);
    localparam logic [9:0] CWD_L    = 10'(T_CWD);
    localparam logic [9:0] BURST_L  = 10'(T_BURST);
    // Cycles-since-PRE value in the last cycle before IDLE is re-entered at PRE+T_RP-1.
    localparam logic [7:0] RP_LAST  = 8'(T_RP - 2);

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic [15:0] row_q;
    logic [9:0]  col_q;
    logic [1:0]  bank_q;
    logic [2:0]  bg_q;
    logic [8:0]  cnt_act;   // cycles since ACT0, saturating
    logic [8:0]  cnt_cas;   // cycles since CAS0, saturating
    logic [7:0]  rp_cnt;    // cycles since PRE
    logic        cas_seen;
    logic        burst_wr;
    logic        accept;
    logic        accept_legal;
    logic [9:0]  act_nxt;
    logic [9:0]  cas_nxt;
    logic [9:0]  burst_lat;
    logic        pre_ok;

    assign accept       = req_valid && req_ready;
    assign accept_legal = accept && (req_op != OP_ILLEGAL);
    // Elapsed counts as they will be in the following cycle: a transition decided now lands there.
    assign act_nxt      = {1'b0, cnt_act} + 10'd1;
    assign cas_nxt      = {1'b0, cnt_cas} + 10'd1;
    assign pre_ok       = (act_nxt >= RAS_L) &&
                          (cas_nxt >= ((op_q == OP_WRITE) ? WR_PRE_L : RTP_L));

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (accept_legal) state_nxt = S_ACT0;
            S_ACT0:     state_nxt = S_ACT1;
            S_ACT1,
            S_WAIT_CAS: state_nxt = (act_nxt >= RCD_L) ? S_CAS0 : S_WAIT_CAS;
            S_CAS0:     state_nxt = S_CAS1;
            S_CAS1,
            S_WAIT_PRE: state_nxt = pre_ok ? S_PRE : S_WAIT_PRE;
            S_PRE,
            S_WAIT_RP:  state_nxt = (rp_cnt >= RP_LAST) ? S_IDLE : S_WAIT_RP;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (state == S_IDLE);
        cmd       = CMD_NULL;
        case (state)
            S_ACT0:  cmd = CMD_ACT0;
            S_ACT1:  cmd = CMD_ACT1;
            S_CAS0:  cmd = (op_q == OP_WRITE) ? CMD_WR0 : CMD_RD0;
            S_CAS1:  cmd = (op_q == OP_WRITE) ? CMD_WR1 : CMD_RD1;
            S_PRE:   cmd = CMD_PRE;
            default: cmd = CMD_NULL;
        endcase
        cmd_valid = (cmd != CMD_NULL);
        cmd_bg    = cmd_valid ? bg_q   : '0;
        cmd_bank  = cmd_valid ? bank_q : '0;
        cmd_row   = cmd_valid ? row_q  : '0;
        cmd_col   = cmd_valid ? col_q  : '0;
    end

    // The data burst is timed purely from CAS0, so it may outlive PRE and run into WAIT_RP.
    assign burst_lat    = burst_wr ? CWD_L : CL_L;
    assign burst_active = cas_seen &&
                          ({1'b0, cnt_cas} >= burst_lat) &&
                          ({1'b0, cnt_cas} <  (burst_lat + BURST_L));

    // Request capture, timers and error pulse
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            op_q     <= '0;
            row_q    <= '0;
            col_q    <= '0;
            bank_q   <= '0;
            bg_q     <= '0;
            cnt_act  <= '0;
            cnt_cas  <= '0;
            rp_cnt   <= '0;
            cas_seen <= 1'b0;
            burst_wr <= 1'b0;
            err_op   <= 1'b0;
        end else begin
            err_op <= accept && (req_op == OP_ILLEGAL);

            if (accept_legal) begin
                op_q    <= req_op;
                row_q   <= req_row;
                col_q   <= req_col;
                bank_q  <= req_bank;
                bg_q    <= req_bg;
                cnt_act <= '0;
            end else if (cnt_act != 9'h1FF) begin
                cnt_act <= cnt_act + 9'd1;
            end

            if (state_nxt == S_CAS0) begin
                cnt_cas  <= '0;
                cas_seen <= 1'b1;
                burst_wr <= (op_q == OP_WRITE);
            end else if (cnt_cas != 9'h1FF) begin
                cnt_cas <= cnt_cas + 9'd1;
            end

            if (state_nxt == S_PRE)   rp_cnt <= '0;
            else if (state == S_PRE || state == S_WAIT_RP) rp_cnt <= rp_cnt + 8'd1;
        end
    end

endmodule
